// File: rtl/xbar_pkg.sv
// Shared crossbar constants: port indices and default geometry.
// Pure definitions, no logic.
package xbar_pkg;

    localparam int P_LOCAL = 0;
    localparam int P_NORTH = 1;
    localparam int P_EAST  = 2;
    localparam int P_WEST  = 3;
    localparam int P_SOUTH = 4;

    localparam int XBAR_WIDTH  = 8;
    localparam int XBAR_PORTS  = 5;
    localparam int XBAR_DEST_W = 3;

    // Pointer/index width for an n-entry round-robin; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_rr_switch_if.sv
// Flit bus between the crossbar and its neighbours: per-port valid/ready on both sides.
// master drives flits in and accepts flits out; slave is the switch side.
interface xbar_rr_switch_if
    import xbar_pkg::*;
#(
    parameter int WIDTH  = XBAR_WIDTH,
    parameter int PORTS  = XBAR_PORTS,
    parameter int DEST_W = XBAR_DEST_W
) ();

    logic [PORTS*WIDTH-1:0]  in_data;
    logic [PORTS-1:0]        in_valid;
    logic [PORTS*DEST_W-1:0] in_dest;
    logic [PORTS-1:0]        in_last;
    logic [PORTS-1:0]        in_ready;
    logic [PORTS*WIDTH-1:0]  out_data;
    logic [PORTS-1:0]        out_valid;
    logic [PORTS-1:0]        out_last;
    logic [PORTS-1:0]        out_ready;
    logic [PORTS-1:0]        drop;

    modport master (
        output in_data, in_valid, in_dest, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, drop
    );

    modport slave (
        input  in_data, in_valid, in_dest, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, drop
    );

endinterface

// File: rtl/xbar_rr_switch_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i, wrapping.
// Purely combinational, no backpressure of its own.
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter  int N     = XBAR_PORTS,
    localparam int PTR_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic [N-1:0] mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] gnt_hi;
    logic [N-1:0] gnt_lo;

    always_comb begin
        mask = '0;
        for (int j = 0; j < N; j++) begin
            mask[j] = (j >= int'(ptr_i));
        end
    end

    // Lowest set bit of the upper (>= ptr) slice wins; otherwise wrap to the lowest overall.
    assign req_hi = req_i & mask;
    assign gnt_hi = req_hi & (~req_hi + N'(1));
    assign gnt_lo = req_i & (~req_i + N'(1));
    assign gnt_o  = (|req_hi) ? gnt_hi : gnt_lo;

endmodule

// File: rtl/xbar_rr_switch.sv
// PORTSxPORTS flit crossbar, per-output round-robin, one register stage per output; XBAR_PKT_LOCK_EN holds an output for a whole packet.
// Latency 1 cycle; an output loads when empty or out_ready, and in_ready follows that load enable combinationally.
module xbar_rr_switch
    import xbar_pkg::*;
#(
    parameter int WIDTH  = XBAR_WIDTH,
    parameter int PORTS  = XBAR_PORTS,
    parameter int DEST_W = XBAR_DEST_W
) (
    input  logic            clk,
    input  logic            rst_n,
    xbar_rr_switch_if.slave bus
);

    localparam int PTR_W = idx_width(PORTS);

    logic [PORTS-1:0] req [PORTS];
    logic [PORTS-1:0] gnt [PORTS];
    logic [PORTS-1:0] dest_ok;
    logic [PORTS-1:0] ld;
    logic [PORTS-1:0] xfer;
    logic [PORTS-1:0] in_rdy;
    logic [PORTS-1:0] mux_last;
    logic [PORTS-1:0][WIDTH-1:0] mux_dat;
    logic [PORTS-1:0][PTR_W-1:0] gnt_idx;

    logic [PORTS-1:0][WIDTH-1:0] out_data_q, out_data_d;
    logic [PORTS-1:0]            out_vld_q, out_vld_d;
    logic [PORTS-1:0]            out_last_q, out_last_d;
    logic [PORTS-1:0]            drop_q, drop_d;
    logic [PORTS-1:0][PTR_W-1:0] rr_ptr_q, rr_ptr_d;
`ifdef XBAR_PKT_LOCK_EN
    logic [PORTS-1:0]            lock_vld_q, lock_vld_d;
    logic [PORTS-1:0][PTR_W-1:0] lock_src_q, lock_src_d;
`endif

    always_comb begin
        dest_ok = '0;
        for (int i = 0; i < PORTS; i++) begin
            dest_ok[i] = int'(bus.in_dest[i*DEST_W +: DEST_W]) < PORTS;
        end
        for (int o = 0; o < PORTS; o++) begin
            req[o] = '0;
            for (int i = 0; i < PORTS; i++) begin
                req[o][i] = bus.in_valid[i] && dest_ok[i]
                         && (int'(bus.in_dest[i*DEST_W +: DEST_W]) == o);
`ifdef XBAR_PKT_LOCK_EN
                // A locked output only listens to the input that opened the packet.
                if (lock_vld_q[o] && (lock_src_q[o] != PTR_W'(i))) req[o][i] = 1'b0;
`endif
            end
        end
    end

    for (genvar o = 0; o < PORTS; o++) begin : g_arb
        rr_arbiter #(.N(PORTS)) u_arb (
            .req_i (req[o]),
            .ptr_i (rr_ptr_q[o]),
            .gnt_o (gnt[o])
        );
    end

    always_comb begin
        ld = '0; xfer = '0; in_rdy = '0; mux_last = '0; mux_dat = '0; gnt_idx = '0;
        out_data_d = out_data_q; out_vld_d = out_vld_q; out_last_d = out_last_q;
        rr_ptr_d = rr_ptr_q; drop_d = '0;
`ifdef XBAR_PKT_LOCK_EN
        lock_vld_d = lock_vld_q; lock_src_d = lock_src_q;
`endif
        for (int o = 0; o < PORTS; o++) begin
            ld[o]   = !out_vld_q[o] || bus.out_ready[o];
            xfer[o] = ld[o] && (|gnt[o]);
            for (int i = 0; i < PORTS; i++) begin
                if (gnt[o][i]) begin
                    mux_dat[o]  = bus.in_data[i*WIDTH +: WIDTH];
                    mux_last[o] = bus.in_last[i];
                    gnt_idx[o]  = PTR_W'(i);
                end
                if (gnt[o][i] && ld[o]) in_rdy[i] = 1'b1;
            end
            out_vld_d[o] = xfer[o] || (out_vld_q[o] && !bus.out_ready[o]);
            if (xfer[o]) begin
                out_data_d[o] = mux_dat[o];
                out_last_d[o] = mux_last[o];
                rr_ptr_d[o]   = (gnt_idx[o] == PTR_W'(PORTS-1)) ? '0 : gnt_idx[o] + PTR_W'(1);
`ifdef XBAR_PKT_LOCK_EN
                lock_vld_d[o] = !mux_last[o];
                lock_src_d[o] = gnt_idx[o];
`endif
            end
        end
        // Unroutable flits are swallowed so they cannot block their input.
        for (int i = 0; i < PORTS; i++) begin
            if (!dest_ok[i]) in_rdy[i] = 1'b1;
            drop_d[i] = bus.in_valid[i] && !dest_ok[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_vld_q  <= '0;
            out_last_q <= '0;
            drop_q     <= '0;
            rr_ptr_q   <= '0;
`ifdef XBAR_PKT_LOCK_EN
            lock_vld_q <= '0;
            lock_src_q <= '0;
`endif
        end else begin
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            drop_q     <= drop_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef XBAR_PKT_LOCK_EN
            lock_vld_q <= lock_vld_d;
            lock_src_q <= lock_src_d;
`endif
        end
    end

    assign bus.in_ready  = rst_n ? in_rdy : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_vld_q;
    assign bus.out_last  = out_last_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_xbar_rr_switch.sv
// Bench for xbar_rr_switch: vector table plus hand sequences, accepted flits tracked in a scoreboard queue.
// Builds with or without XBAR_PKT_LOCK_EN; the lock sequence picks its expectations accordingly.
module tb_xbar_rr_switch;
    import xbar_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    xbar_rr_switch_if #(.WIDTH(8), .PORTS(5), .DEST_W(3)) bus ();

    xbar_rr_switch #(.WIDTH(8), .PORTS(5), .DEST_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         port;
        logic [7:0] dat;
        logic       last;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       nm;
        logic [4:0]  vld;
        logic [14:0] dst;
        logic [39:0] dat;
        logic [4:0]  lst;
        logic [4:0]  ordy;
        logic [4:0]  rdy;
        logic [4:0]  ovld;
        logic [4:0]  drp;
    } vec_t;
    vec_t tbl[11];

    function automatic logic [14:0] dst5(input int a4, input int a3, input int a2, input int a1, input int a0);
        return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    function automatic logic [39:0] dat5(input logic [7:0] a4, input logic [7:0] a3, input logic [7:0] a2,
                                         input logic [7:0] a1, input logic [7:0] a0);
        return {a4, a3, a2, a1, a0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] vld, input logic [14:0] dst, input logic [39:0] dat,
                         input logic [4:0] lst, input logic [4:0] ordy);
        bus.in_valid  = vld;
        bus.in_dest   = dst;
        bus.in_data   = dat;
        bus.in_last   = lst;
        bus.out_ready = ordy;
    endtask

    // One clock of stimulus: flits expected to be accepted go into the scoreboard and must appear next cycle.
    task automatic cycle(input string nm, input logic [4:0] vld, input logic [14:0] dst, input logic [39:0] dat,
                         input logic [4:0] lst, input logic [4:0] ordy, input logic [4:0] e_rdy,
                         input logic [4:0] e_vld, input logic [4:0] e_drop);
        sb_t e;
        @(negedge clk);
        drive(vld, dst, dat, lst, ordy);
        for (int i = 0; i < 5; i++) begin
            if (vld[i] && e_rdy[i] && (dst[i*3 +: 3] < 3'd5))
                sb_q.push_back('{int'(dst[i*3 +: 3]), dat[i*8 +: 8], lst[i]});
        end
        #4;
        chk({nm, " in_ready"}, 64'(bus.in_ready), 64'(e_rdy));
        @(posedge clk);
        #1;
        chk({nm, " out_valid"}, 64'(bus.out_valid), 64'(e_vld));
        chk({nm, " drop"}, 64'(bus.drop), 64'(e_drop));
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("%s out_data[%0d]", nm, e.port), 64'(bus.out_data[e.port*8 +: 8]), 64'(e.dat));
            chk($sformatf("%s out_last[%0d]", nm, e.port), 64'(bus.out_last[e.port]), 64'(e.last));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{"idle",      5'b00000, 15'd0, 40'd0, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000};
        tbl[1]  = '{"single",    5'b00010, dst5(0, 0, 0, P_WEST, 0), dat5(0, 0, 0, 8'hA5, 0),
                    5'b00010, 5'b11111, 5'b00010, 5'b01000, 5'b00000};
        tbl[2]  = '{"rr0",       5'b10101, dst5(P_NORTH, 0, P_NORTH, 0, P_NORTH), dat5(8'h44, 0, 8'h42, 0, 8'h40),
                    5'b10101, 5'b11111, 5'b00001, 5'b00010, 5'b00000};
        tbl[3]  = '{"rr2",       5'b10101, dst5(P_NORTH, 0, P_NORTH, 0, P_NORTH), dat5(8'h54, 0, 8'h52, 0, 8'h50),
                    5'b00000, 5'b11111, 5'b00100, 5'b00010, 5'b00000};
        tbl[4]  = '{"rr4",       5'b10101, dst5(P_NORTH, 0, P_NORTH, 0, P_NORTH), dat5(8'h64, 0, 8'h62, 0, 8'h60),
                    5'b00000, 5'b11111, 5'b10000, 5'b00010, 5'b00000};
        tbl[5]  = '{"rr_wrap0",  5'b10101, dst5(P_NORTH, 0, P_NORTH, 0, P_NORTH), dat5(8'h74, 0, 8'h72, 0, 8'h70),
                    5'b00000, 5'b11111, 5'b00001, 5'b00010, 5'b00000};
        tbl[6]  = '{"bad_dest7", 5'b00001, dst5(0, 0, 0, 0, 7), dat5(0, 0, 0, 0, 8'hEE),
                    5'b00000, 5'b11111, 5'b00001, 5'b00000, 5'b00001};
        tbl[7]  = '{"drop_clr",  5'b00000, 15'd0, 40'd0, 5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000};
        tbl[8]  = '{"parallel",  5'b11111, dst5(P_EAST, P_LOCAL, P_NORTH, P_SOUTH, P_EAST),
                    dat5(8'h84, 8'h83, 8'h82, 8'h81, 8'h80), 5'b01010, 5'b11111, 5'b01111, 5'b10111, 5'b00000};
        tbl[9]  = '{"loser_next", 5'b10000, dst5(P_EAST, 0, 0, 0, 0), dat5(8'h94, 0, 0, 0, 0),
                    5'b10000, 5'b11111, 5'b10000, 5'b00100, 5'b00000};
        tbl[10] = '{"bad_dest5", 5'b00011, dst5(0, 0, 0, P_LOCAL, 5), dat5(0, 0, 0, 8'hA1, 8'hA0),
                    5'b00010, 5'b11111, 5'b00011, 5'b00001, 5'b00001};

        rst_n = 1'b1;
        drive(5'b0, 15'd0, 40'd0, 5'b0, 5'b11111);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_data", 64'(bus.out_data), 64'd0);
        chk("reset out_last", 64'(bus.out_last), 64'd0);
        chk("reset drop", 64'(bus.drop), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int k = 0; k < 11; k++) begin
            cycle(tbl[k].nm, tbl[k].vld, tbl[k].dst, tbl[k].dat, tbl[k].lst, tbl[k].ordy,
                  tbl[k].rdy, tbl[k].ovld, tbl[k].drp);
        end

        // Backpressure on output East: held flit stays put, release admits the next winner at once.
        cycle("bp_idle", 5'b0, 15'd0, 40'd0, 5'b0, 5'b11111, 5'b00000, 5'b00000, 5'b00000);
        cycle("bp_load", 5'b01000, dst5(0, P_EAST, 0, 0, 0), dat5(0, 8'hC3, 0, 0, 0),
              5'b01000, 5'b11111, 5'b01000, 5'b00100, 5'b00000);
        for (int r = 0; r < 2; r++) begin
            cycle($sformatf("bp_stall%0d", r), 5'b01010, dst5(0, P_EAST, 0, P_EAST, 0),
                  dat5(0, 8'hD3, 0, 8'hB1, 0), 5'b00000, 5'b11011, 5'b00000, 5'b00100, 5'b00000);
            chk($sformatf("bp_stall%0d hold data", r), 64'(bus.out_data[2*8 +: 8]), 64'hC3);
            chk($sformatf("bp_stall%0d hold last", r), 64'(bus.out_last[2]), 64'd1);
        end
        cycle("bp_release", 5'b01010, dst5(0, P_EAST, 0, P_EAST, 0), dat5(0, 8'hD3, 0, 8'hB1, 0),
              5'b00000, 5'b11111, 5'b00010, 5'b00100, 5'b00000);
        cycle("bp_drain", 5'b0, 15'd0, 40'd0, 5'b0, 5'b11111, 5'b00000, 5'b00000, 5'b00000);

        // Reset with North holding a flit and its pointer moved past input 2.
        cycle("pre_rst", 5'b00100, dst5(0, 0, P_NORTH, 0, 0), dat5(0, 0, 8'h2A, 0, 0),
              5'b00100, 5'b11111, 5'b00100, 5'b00010, 5'b00000);
        @(negedge clk);
        drive(5'b10100, dst5(P_NORTH, 0, P_NORTH, 0, 0), dat5(8'h4B, 0, 8'h2B, 0, 0), 5'b10100, 5'b00000);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst out_data", 64'(bus.out_data), 64'd0);
        chk("midrst out_last", 64'(bus.out_last), 64'd0);
        chk("midrst in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst held out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        drive(5'b0, 15'd0, 40'd0, 5'b0, 5'b11111);
        rst_n = 1'b1;
        cycle("post_rst", 5'b10100, dst5(P_NORTH, 0, P_NORTH, 0, 0), dat5(8'h4B, 0, 8'h2B, 0, 0),
              5'b10100, 5'b11111, 5'b00100, 5'b00010, 5'b00000);
        cycle("post_rst_idle", 5'b0, 15'd0, 40'd0, 5'b0, 5'b11111, 5'b00000, 5'b00000, 5'b00000);

        // Input 1 sends a 3-flit packet to Local while input 2 keeps requesting Local.
`ifdef XBAR_PKT_LOCK_EN
        cycle("lock_f1", 5'b00110, dst5(0, 0, P_LOCAL, P_LOCAL, 0), dat5(0, 0, 8'h22, 8'h11, 0),
              5'b00100, 5'b11111, 5'b00010, 5'b00001, 5'b00000);
        cycle("lock_f2", 5'b00110, dst5(0, 0, P_LOCAL, P_LOCAL, 0), dat5(0, 0, 8'h22, 8'h12, 0),
              5'b00100, 5'b11111, 5'b00010, 5'b00001, 5'b00000);
        cycle("lock_f3", 5'b00110, dst5(0, 0, P_LOCAL, P_LOCAL, 0), dat5(0, 0, 8'h22, 8'h13, 0),
              5'b00110, 5'b11111, 5'b00010, 5'b00001, 5'b00000);
        cycle("lock_rel", 5'b00110, dst5(0, 0, P_LOCAL, P_LOCAL, 0), dat5(0, 0, 8'h22, 8'h14, 0),
              5'b00100, 5'b11111, 5'b00100, 5'b00001, 5'b00000);
`else
        cycle("nolock_f1", 5'b00110, dst5(0, 0, P_LOCAL, P_LOCAL, 0), dat5(0, 0, 8'h22, 8'h11, 0),
              5'b00100, 5'b11111, 5'b00010, 5'b00001, 5'b00000);
        cycle("nolock_in2", 5'b00110, dst5(0, 0, P_LOCAL, P_LOCAL, 0), dat5(0, 0, 8'h22, 8'h12, 0),
              5'b00100, 5'b11111, 5'b00100, 5'b00001, 5'b00000);
        cycle("nolock_f2", 5'b00110, dst5(0, 0, P_LOCAL, P_LOCAL, 0), dat5(0, 0, 8'h22, 8'h12, 0),
              5'b00100, 5'b11111, 5'b00010, 5'b00001, 5'b00000);
        cycle("nolock_f3", 5'b00110, dst5(0, 0, P_LOCAL, P_LOCAL, 0), dat5(0, 0, 8'h22, 8'h13, 0),
              5'b00110, 5'b11111, 5'b00100, 5'b00001, 5'b00000);
`endif
        cycle("final_idle", 5'b0, 15'd0, 40'd0, 5'b0, 5'b11111, 5'b00000, 5'b00000, 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/xbar_rr_switch.md
XBAR_RR_SWITCH -- requirements
Module: xbar_rr_switch

Interface
REQ-001 Parameter WIDTH, default 8, flit data width in bits.
REQ-002 Parameter PORTS, default 5, number of input and output ports (index 0=Local, 1=N, 2=E, 3=W, 4=S).
REQ-003 Parameter DEST_W, default 3, width of each per-input destination field; SHALL be >= clog2(PORTS).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  PORTS*WIDTH  packed input flits; port i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  PORTS  per-input flit-valid.
REQ-008 in_dest  input  PORTS*DEST_W  per-input destination output index.
REQ-009 in_last  input  PORTS  per-input last-flit-of-packet marker.
REQ-010 in_ready  output  PORTS  per-input accept; a transfer occurs when in_valid[i] & in_ready[i].
REQ-011 out_data  output  PORTS*WIDTH  packed registered output flits.
REQ-012 out_valid  output  PORTS  per-output flit-valid.
REQ-013 out_last  output  PORTS  registered copy of the accepted flit's in_last.
REQ-014 out_ready  input  PORTS  downstream accept per output.
REQ-015 drop  output  PORTS  one-cycle pulse per input whose flit was discarded for an invalid destination.

Function
REQ-016 Input i requests output o when in_valid[i] and in_dest[i]==o and in_dest[i] < PORTS.
REQ-017 Each output holds one register stage; load enable ld[o] = !out_valid[o] | out_ready[o].
REQ-018 Each output arbitrates independently by round-robin: search starts at rr_ptr[o] and wraps modulo PORTS; the first requester found is granted.
REQ-019 in_ready[i] SHALL be 1 only when i is granted by output in_dest[i] and ld of that output is 1; it may depend combinationally on out_ready.
REQ-020 On transfer from input i to output o: out_data[o], out_last[o] load in_data[i], in_last[i]; out_valid[o] set; rr_ptr[o] <= (i+1) mod PORTS, wrapping PORTS-1 -> 0.
REQ-021 When out_ready[o] is 1 and no transfer targets o, out_valid[o] clears; when it is 0 and out_valid[o] is 1, out_data/out_last/out_valid hold.
REQ-022 Latency input-accept to out_valid is exactly one cycle; full throughput of one flit per output per cycle under continuous out_ready.
REQ-023 A flit with in_dest >= PORTS SHALL be accepted (in_ready=1) and discarded, and drop[i] pulses for that cycle, registered one cycle later.
REQ-024 Multiple outputs may grant different inputs in the same cycle; an input is granted at most once, since it names one destination.
REQ-025 rr_ptr[o] SHALL not advance in a cycle without a transfer to o.

Reset
REQ-026 While rst_n=0: out_valid, out_last, drop, rr_ptr, and lock state are 0; out_data is 0; in_ready is 0.
REQ-027 Reset asserted mid-transfer discards held flits and any packet lock; operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-028 Macro XBAR_PKT_LOCK_EN defined: when output o accepts a flit with in_last=0, o locks to that input; while locked, only that input may be granted; the lock releases on transfer of its in_last=1 flit, and rr_ptr then advances.
REQ-029 XBAR_PKT_LOCK_EN undefined: no lock state exists; every flit re-arbitrates per REQ-018 and in_last is only passed through to out_last.

Structure
REQ-030 A shared package xbar_pkg SHALL hold port index constants (P_LOCAL=0, P_NORTH=1, P_EAST=2, P_WEST=3, P_SOUTH=4) and the default PORTS and DEST_W.
REQ-031 Round-robin arbitration SHALL be a sub-module rr_arbiter (request vector, pointer -> one-hot grant), instantiated once per output.

Verification
REQ-032 Single flit: in_valid[1]=1, in_dest[1]=3, in_data=8'hA5, out_ready=all 1 -> next cycle out_valid[3]=1, out_data[3]=8'hA5, all others 0.
REQ-033 Contention: inputs 0, 2, 4 drive continuously to output 1 with rr_ptr=0 -> grants follow order 0, 2, 4, 0, one per cycle.
REQ-034 Backpressure: out_ready[2]=0 with out_valid[2]=1 -> in_ready to requesters of output 2 is 0 and out_data[2] holds; releasing out_ready accepts the next flit the same cycle.
REQ-035 Invalid destination: in_dest[0]=7 with PORTS=5 -> in_ready[0]=1, drop[0]=1 next cycle, no out_valid change.
REQ-036 Packet lock (macro defined): input 1 sends a 3-flit packet to output 0 while input 2 also requests it -> all 3 flits of input 1 are delivered contiguously before input 2 is granted.
REQ-037 Reset mid-packet: assert rst_n=0 with out_valid set and lock active -> all outputs 0 immediately; after release, input 2 is granted first by rr_ptr=0 search.
